// File: rtl/systolic_feeder.sv
// Edge feeder for an N x N systolic array: one A column and one B row per beat,
// with lane i delayed by i cycles so operands meet diagonally, and a zero flush at stream end.
module systolic_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int N          = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_last,
  input  logic [N*DATA_WIDTH-1:0] a_vec,
  input  logic [N*DATA_WIDTH-1:0] b_vec,
  output logic [N*DATA_WIDTH-1:0] left_out,
  output logic [N*DATA_WIDTH-1:0] top_out,
  output logic [N-1:0]            left_vld,
  output logic [N-1:0]            top_vld,
  output logic                    busy,
  output logic                    done
);

  // Zeros must travel until the last operand pair reaches PE(N-1,N-1).
  localparam int FLUSH_LEN = 2 * N - 1;
  localparam int CW        = $clog2(FLUSH_LEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FLUSH_LEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    FEED,
    FLUSH
  } state_t;

  state_t          state;
  logic [CW-1:0]   flush_cnt;
  logic            accept;

  assign in_ready = (state != FLUSH);
  assign busy     = (state != IDLE);
  assign accept   = in_valid && in_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      flush_cnt <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, FEED: begin
          if (accept) begin
            if (in_last) begin
              state     <= FLUSH;
              flush_cnt <= '0;
              done      <= (FLUSH_LEN == 1);
            end else begin
              state <= FEED;
            end
          end
        end
        FLUSH: begin
          if (flush_cnt == CNT_LAST) begin
            state <= IDLE;
          end else begin
            flush_cnt <= flush_cnt + 1'b1;
            done      <= (flush_cnt + 1'b1 == CNT_LAST);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Lane i owns i+1 stages; stage 0 takes the new element or a zero bubble.
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [i:0][DATA_WIDTH-1:0] a_d;
    logic [i:0][DATA_WIDTH-1:0] b_d;
    logic [i:0]                 a_v;
    logic [i:0]                 b_v;

    // NOTE: the skew stages are reset explicitly because a mid-stream reset
    // must discard every operand still in flight, not just the control state.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        a_d <= '0;
        b_d <= '0;
        a_v <= '0;
        b_v <= '0;
      end else begin
        a_d[0] <= accept ? a_vec[i*DATA_WIDTH +: DATA_WIDTH] : '0;
        b_d[0] <= accept ? b_vec[i*DATA_WIDTH +: DATA_WIDTH] : '0;
        a_v[0] <= accept;
        b_v[0] <= accept;
        for (int s = 1; s <= i; s++) begin
          a_d[s] <= a_d[s-1];
          b_d[s] <= b_d[s-1];
          a_v[s] <= a_v[s-1];
          b_v[s] <= b_v[s-1];
        end
      end
    end

    assign left_out[i*DATA_WIDTH +: DATA_WIDTH] = a_d[i];
    assign top_out[i*DATA_WIDTH +: DATA_WIDTH]  = b_d[i];
    assign left_vld[i]                          = a_v[i];
    assign top_vld[i]                           = b_v[i];
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Scoreboard bench for systolic_feeder: accepted beats are queued per lane with the
// edge at which they must emerge; a small handshake model predicts ready/busy/done.
module tb_systolic_feeder;

  localparam int N  = 4;
  localparam int DW = 8;

  typedef logic [N*DW-1:0] vec_t;
  typedef struct {
    int            tgt;
    logic [DW-1:0] d;
  } ent_t;

  logic clk;
  logic rst;
  logic in_valid;
  logic in_ready;
  logic in_last;
  vec_t a_vec;
  vec_t b_vec;
  vec_t left_out;
  vec_t top_out;
  logic [N-1:0] left_vld;
  logic [N-1:0] top_vld;
  logic busy;
  logic done;

  systolic_feeder #(.DATA_WIDTH(DW), .N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_last  (in_last),
    .a_vec    (a_vec),
    .b_vec    (b_vec),
    .left_out (left_out),
    .top_out  (top_out),
    .left_vld (left_vld),
    .top_vld  (top_vld),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_errors = 0;
  int   edge_n   = 0;
  int   m_state  = 0;   // 0 idle, 1 feed, 2 flush
  int   m_fcnt   = 0;   // flush cycle number, 1-based
  logic last_acc = 1'b0;
  ent_t qa [N][$];
  ent_t qb [N][$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  task automatic sample();
    for (int i = 0; i < N; i++) begin
      logic [DW-1:0] ea;
      logic [DW-1:0] eb;
      logic          va;
      logic          vb;
      ea = '0; eb = '0; va = 1'b0; vb = 1'b0;
      if (qa[i].size() > 0 && qa[i][0].tgt == edge_n) begin
        ea = qa[i][0].d; va = 1'b1; void'(qa[i].pop_front());
      end
      if (qb[i].size() > 0 && qb[i][0].tgt == edge_n) begin
        eb = qb[i][0].d; vb = 1'b1; void'(qb[i].pop_front());
      end
      check($sformatf("left_out[%0d]", i), 32'(left_out[i*DW +: DW]), 32'(ea));
      check($sformatf("left_vld[%0d]", i), 32'(left_vld[i]), 32'(va));
      check($sformatf("top_out[%0d]", i), 32'(top_out[i*DW +: DW]), 32'(eb));
      check($sformatf("top_vld[%0d]", i), 32'(top_vld[i]), 32'(vb));
    end
    check("in_ready", 32'(in_ready), 32'(m_state != 2));
    check("busy", 32'(busy), 32'(m_state != 0));
    check("done", 32'(done), 32'(m_state == 2 && m_fcnt == 2 * N - 1));
  endtask

  // Drive one cycle of stimulus, update the scoreboard/model at the edge, sample at negedge.
  task automatic step(input logic v, input logic l, input vec_t a, input vec_t b);
    logic acc;
    in_valid = v; in_last = l; a_vec = a; b_vec = b;
    @(posedge clk);
    edge_n++;
    acc      = v && (m_state != 2);
    last_acc = acc;
    if (acc) begin
      for (int i = 0; i < N; i++) begin
        qa[i].push_back('{edge_n + i, a[i*DW +: DW]});
        qb[i].push_back('{edge_n + i, b[i*DW +: DW]});
      end
    end
    case (m_state)
      0, 1: if (acc) begin
        if (l) begin m_state = 2; m_fcnt = 1; end
        else m_state = 1;
      end
      default: begin
        if (m_fcnt == 2 * N - 1) m_state = 0;
        else m_fcnt++;
      end
    endcase
    @(negedge clk);
    sample();
  endtask

  task automatic idle(input int cycles);
    for (int c = 0; c < cycles; c++) step(1'b0, 1'b0, '0, '0);
  endtask

  function automatic vec_t fill(input int base, input int stride, input int k);
    vec_t v;
    for (int i = 0; i < N; i++) v[i*DW +: DW] = DW'(base + stride * i + k);
    return v;
  endfunction

  task automatic check_cleared(input string tag);
    check({tag, "_left_vld"}, 32'(left_vld), 32'd0);
    check({tag, "_top_vld"}, 32'(top_vld), 32'd0);
    check({tag, "_left_out"}, 32'(left_out), 32'd0);
    check({tag, "_top_out"}, 32'(top_out), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int held;
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; a_vec = '0; b_vec = '0;
    #2;
    check_cleared("reset");
    @(negedge clk);
    rst = 1'b0;

    // Idle after reset.
    idle(10);

    // Single beat with in_last: lane 0 shows 1/5, lane 3 shows 4/8 three cycles later.
    step(1'b1, 1'b1, 32'h04030201, 32'h08070605);
    idle(2 * N + 2);

    // Four back-to-back beats, A[i][k] = 10*i + k.
    for (int k = 0; k < 4; k++) step(1'b1, k == 3, fill(0, 10, k), fill(100, 10, k));
    idle(2 * N + 2);

    // Bubble between two beats.
    step(1'b1, 1'b0, fill(1, 1, 0), fill(50, 3, 0));
    step(1'b0, 1'b0, fill(9, 9, 9), fill(9, 9, 9));
    step(1'b1, 1'b1, fill(20, 1, 0), fill(70, 3, 0));
    idle(2 * N + 2);

    // in_valid held through FLUSH: rejected for 2N-1 cycles, accepted in first IDLE cycle.
    step(1'b1, 1'b1, fill(30, 2, 0), fill(40, 2, 0));
    held = 0;
    do begin
      step(1'b1, 1'b1, {N{8'h55}}, {N{8'h55}});
      held++;
    end while (!last_acc && held < 20);
    check("flush_hold_len", 32'(held), 32'(2 * N));
    idle(2 * N + 2);

    // Reset with two beats in flight during FEED.
    step(1'b1, 1'b0, fill(60, 1, 0), fill(80, 1, 0));
    step(1'b1, 1'b0, fill(61, 1, 0), fill(81, 1, 0));
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1 check_cleared("async_rst");
    for (int i = 0; i < N; i++) begin qa[i].delete(); qb[i].delete(); end
    m_state = 0; m_fcnt = 0;
    @(negedge clk);
    rst = 1'b0;
    check_cleared("post_rst");
    idle(3);

    // Stream after reset behaves like the first single-beat case.
    step(1'b1, 1'b1, 32'h04030201, 32'h08070605);
    idle(2 * N + 2);

    for (int i = 0; i < N; i++) begin
      check($sformatf("drain_a[%0d]", i), 32'(qa[i].size()), 32'd0);
      check($sformatf("drain_b[%0d]", i), 32'(qb[i].size()), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/systolic_feeder.md
# systolic_feeder

- Drives the left and top edges of an N×N systolic PE array.
- Accepts one beat per handshake: a column of A and a row of B, N elements each.
- Re-times lane i by i extra cycles, producing the diagonal wavefront the array needs.
- After the last beat it flushes zeros until the final operands have reached PE(N-1,N-1), then pulses `done`.

## Interface
- `DATA_WIDTH`, 8, element width in bits.
- `N`, 4, array dimension: number of row lanes and column lanes.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `in_valid` input 1: a beat is offered on `a_vec`, `b_vec` and `in_last`.
- `in_ready` output 1: feeder can accept a beat this cycle.
- `in_last` input 1: the offered beat is the final beat of the stream (k = K-1).
- `a_vec` input N*DATA_WIDTH: A[i][k] in bits [i*DATA_WIDTH +: DATA_WIDTH], i = row lane.
- `b_vec` input N*DATA_WIDTH: B[k][j] in bits [j*DATA_WIDTH +: DATA_WIDTH], j = column lane.
- `left_out` output N*DATA_WIDTH: lane i drives `left_in` of PE(i,0).
- `top_out` output N*DATA_WIDTH: lane j drives `top_in` of PE(0,j).
- `left_vld` output N: per-lane qualifier, skewed identically to `left_out`.
- `top_vld` output N: per-lane qualifier, skewed identically to `top_out`.
- `busy` output 1: state is not IDLE.
- `done` output 1: one-cycle pulse on the last FLUSH cycle.

## Operation
- States:
  - IDLE: `in_ready`=1.
  - FEED: `in_ready`=1.
  - FLUSH: `in_ready`=0.
- Transitions:
  - IDLE→FEED on an accepted beat with `in_last`=0.
  - IDLE→FLUSH on an accepted beat with `in_last`=1 (K=1 is legal).
  - FEED→FLUSH on an accepted beat with `in_last`=1.
  - FLUSH→IDLE after exactly 2N-1 cycles, counted by a flush counter.
- Accept = `in_valid`&`in_ready` at a rising edge. `in_valid` in FLUSH is ignored; the beat is neither lost nor consumed and stays pending for IDLE.
- Skew chain: lane i of A and lane j of B each use a shift register of i+1 (resp. j+1) stages. Stage 0 loads the element on accept, else loads 0 with vld=0 (bubble).
- A bubble in FEED (`in_valid`=0) propagates as data 0 / vld 0; stream order is preserved.
- FLUSH inserts zero/vld-0 beats at stage 0.
- Data is passed through unmodified; no arithmetic, no width change.
- `rst`: all skew stages, vld bits and the flush counter clear to 0; state returns to IDLE. A reset mid-stream discards everything in flight.

## Timing
- Reset values: `left_out`=0, `top_out`=0, `left_vld`=0, `top_vld`=0, `busy`=0, `done`=0, `in_ready`=1.
- Latency: a beat accepted at edge t appears on lane i (A) or lane j (B) in the cycle after edge t+i (resp. t+j). Lane 0 has 1 cycle latency; lane N-1 has N cycles.
- Throughput: one beat per cycle in IDLE/FEED.
- FLUSH: starts the cycle after the edge accepting the last beat and lasts 2N-1 cycles (7 for N=4). `done`=1 in the final FLUSH cycle only; IDLE, `busy`=0 and `in_ready`=1 follow in the next cycle.
- Back-to-back streams: `in_valid` held high across the end of FLUSH is accepted in the first IDLE cycle.
- Outputs are registered; there is no combinational path from inputs to `left_out`/`top_out`/`*_vld`. `in_ready` is a function of state only.

## Test plan
- Reset then idle, N=4: all outputs 0, `in_ready`=1, `busy`=0 for 10 cycles; assert `rst` mid-cycle → outputs clear immediately without waiting for `clk`.
- Single beat, `in_last`=1, `a_vec`={4,3,2,1}, `b_vec`={8,7,6,5} (lane 0 at bit 0), accepted at edge 0:
  - lane 0 shows 1/5 after edge 0, lane 3 shows 4/8 after edge 3, each for exactly one cycle;
  - `done` pulses in the 7th FLUSH cycle.
- Four beats k=0..3 back-to-back, element A[i][k]=10*i+k: `left_out` lane i shows 10*i+0..10*i+3 on consecutive cycles starting i cycles after lane 0; `left_vld` matches exactly.
- Bubble: beats at edges 0 and 2, `in_valid`=0 at edge 1 → every lane shows data, 0/vld=0, data, with its skew offset.
- `in_valid`=1 during FLUSH with value 0x55: not accepted (`in_ready`=0), accepted in the first IDLE cycle, appearing on lane 0 one cycle later.
- `rst` asserted while FEED has 2 beats in flight → all vld=0, `busy`=0, no `done`; the next stream after reset behaves as in the single-beat case.
